// File: rtl/fc_pe_array.sv
// fc_pe_array: fully-connected layer compute stage.
// Reads one PARALLEL_FC_PE-wide weight word per input column from the FC weight
// memory, multiplies it against that column's streamed activation in every lane,
// and emits scaled, saturated neuron outputs once per pass.
//
// Ports
//   clk, reset         clock; synchronous active-high reset
//   start              begin a pass (sampled in IDLE only)
//   in_valid/in_ready  activation handshake; in_data is the signed activation
//   address_fc         weight column index to the memory
//   read_en_MM_fc      memory read enable (high on the cycle after each accept)
//   enable_MM_out_fc   memory output-bus enable (RUN and DRAIN)
//   dataMainMemo_fc    weight word; lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_ready result handshake; out_data packed the same way as weights
//   busy               high whenever the FSM is not IDLE
//   done               high on the result handshake cycle
//
// Configuration
//   FC_PE_RELU_EN      when defined, negative saturated lane results become 0
module fc_pe_array #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 9,
    parameter int unsigned PARALLEL_FC_PE = 32,
    parameter int unsigned FC_COLUMNS     = 100,
    parameter int unsigned ACC_WIDTH      = 73,
    parameter int unsigned FRAC_BITS      = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_WIDTH-1:0]                in_data,
    output logic [ADDR_WIDTH-1:0]                address_fc,
    output logic                                 read_en_MM_fc,
    output logic                                 enable_MM_out_fc,
    input  logic [DATA_WIDTH*PARALLEL_FC_PE-1:0] dataMainMemo_fc,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [DATA_WIDTH*PARALLEL_FC_PE-1:0] out_data,
    output logic                                 busy,
    output logic                                 done
);

    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
    localparam int unsigned EXT_WIDTH  = ACC_WIDTH - PROD_WIDTH;
    localparam int unsigned OUT_WIDTH  = DATA_WIDTH * PARALLEL_FC_PE;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]                   state;
    logic [1:0]                   next_state;
    logic [ADDR_WIDTH-1:0]        col;
    logic signed [DATA_WIDTH-1:0] act_reg;
    logic                         pend;
    logic signed [ACC_WIDTH-1:0]  acc     [PARALLEL_FC_PE];
    logic signed [ACC_WIDTH-1:0]  acc_sum [PARALLEL_FC_PE];
    logic [OUT_WIDTH-1:0]         out_next;
    logic                         accept;
    logic                         last_col;
    logic                         handshake;
    logic                         clear_acc;

    assign accept    = in_valid && in_ready;
    assign last_col  = (col == ADDR_WIDTH'(FC_COLUMNS - 1));
    assign handshake = out_valid && out_ready;
    assign clear_acc = (state == S_IDLE) && start;

    // done must coincide with the handshake cycle, so it cannot be registered
    assign done = handshake;

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_RUN;
            S_RUN:   if (accept && last_col) next_state = S_DRAIN;
            S_DRAIN: next_state = S_OUT;
            S_OUT:   if (handshake) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Per-lane MAC sum and output scaling/saturation
    for (genvar k = 0; k < PARALLEL_FC_PE; k++) begin : g_lane
        logic signed [DATA_WIDTH-1:0] w;
        logic signed [PROD_WIDTH-1:0] prod;
        logic signed [ACC_WIDTH-1:0]  shifted;
        logic [ACC_WIDTH-DATA_WIDTH:0] upper;
        logic                         in_range;
        logic [DATA_WIDTH-1:0]        sat_val;
        logic [DATA_WIDTH-1:0]        lane_res;

        assign w    = dataMainMemo_fc[k*DATA_WIDTH +: DATA_WIDTH];
        assign prod = PROD_WIDTH'(act_reg) * PROD_WIDTH'(w);

        // pend marks that act_reg and the memory word belong to an accepted column
        assign acc_sum[k] = acc[k] + (pend ? {{EXT_WIDTH{prod[PROD_WIDTH-1]}}, prod} : '0);

        assign shifted = acc_sum[k] >>> FRAC_BITS;

        // Fits in DATA_WIDTH only if every bit above the result's sign bit matches it
        assign upper    = shifted[ACC_WIDTH-1:DATA_WIDTH-1];
        assign in_range = (&upper) || !(|upper);
        assign sat_val  = in_range ? shifted[DATA_WIDTH-1:0] :
                          shifted[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                                                 {1'b0, {(DATA_WIDTH-1){1'b1}}};

`ifdef FC_PE_RELU_EN
        assign lane_res = sat_val[DATA_WIDTH-1] ? '0 : sat_val;
`else
        assign lane_res = sat_val;
`endif

        assign out_next[k*DATA_WIDTH +: DATA_WIDTH] = lane_res;
    end

    // State register, memory read port, accumulators and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            col              <= '0;
            act_reg          <= '0;
            pend             <= 1'b0;
            address_fc       <= '0;
            read_en_MM_fc    <= 1'b0;
            enable_MM_out_fc <= 1'b0;
            in_ready         <= 1'b0;
            out_valid        <= 1'b0;
            out_data         <= '0;
            busy             <= 1'b0;
            for (int k = 0; k < PARALLEL_FC_PE; k++) begin
                acc[k] <= '0;
            end
        end else begin
            state            <= next_state;
            in_ready         <= (next_state == S_RUN);
            enable_MM_out_fc <= (next_state == S_RUN) || (next_state == S_DRAIN);
            busy             <= (next_state != S_IDLE);

            // Memory sees the address after this edge and answers on the next negedge
            read_en_MM_fc <= accept;
            pend          <= accept;
            if (accept) begin
                address_fc <= col;
                act_reg    <= in_data;
            end

            if (clear_acc) begin
                col <= '0;
            end else if (accept) begin
                col <= last_col ? '0 : col + ADDR_WIDTH'(1);
            end

            for (int k = 0; k < PARALLEL_FC_PE; k++) begin
                acc[k] <= clear_acc ? '0 : acc_sum[k];
            end

            // Final MAC happens on the DRAIN edge, so results come from acc_sum
            if (state == S_DRAIN) begin
                out_data  <= out_next;
                out_valid <= 1'b1;
            end else if (handshake) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
